// File: rtl/mips_instr_encoder.sv
// Symbolic MIPS instruction -> 32-bit word, written to imem at an auto-incrementing pointer.
// Accept -> ENC -> WR (imem_we) -> IDLE: one word per 3 cycles; in_ready low outside IDLE and sticky-low once full.
module mips_instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            mnem,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

    typedef enum logic [4:0] {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_NOR, M_SLL, M_SRL, M_SRA,
        M_SLT, M_JR, M_ANDI, M_ORI, M_SLTI, M_ADDI, M_ADDIU, M_BEQ, M_BNE,
        M_BGTZ, M_BGEZ, M_LW, M_SW, M_LUI, M_J, M_JAL
    } mnem_t;

    typedef struct packed {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_t;

    state_t                state_q, state_d;
    instr_t                instr_q, instr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;

    logic [31:0]           enc_word;
    logic                  enc_legal;

    // Fields a format does not use are forced to zero regardless of their input values.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (instr_q.mnem)
            M_ADD:   enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h20};
            M_ADDU:  enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h21};
            M_SUB:   enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h22};
            M_SUBU:  enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h23};
            M_AND:   enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h24};
            M_OR:    enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h25};
            M_NOR:   enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h27};
            M_SLT:   enc_word = {6'h00, instr_q.rs, instr_q.rt, instr_q.rd, 5'd0, 6'h2A};
            M_SLL:   enc_word = {6'h00, 5'd0, instr_q.rt, instr_q.rd, instr_q.shamt, 6'h00};
            M_SRL:   enc_word = {6'h00, 5'd0, instr_q.rt, instr_q.rd, instr_q.shamt, 6'h02};
            M_SRA:   enc_word = {6'h00, 5'd0, instr_q.rt, instr_q.rd, instr_q.shamt, 6'h03};
            M_JR:    enc_word = {6'h00, instr_q.rs, 15'd0, 6'h08};
            M_ANDI:  enc_word = {6'h0C, instr_q.rs, instr_q.rt, instr_q.imm};
            M_ORI:   enc_word = {6'h0D, instr_q.rs, instr_q.rt, instr_q.imm};
            M_SLTI:  enc_word = {6'h0A, instr_q.rs, instr_q.rt, instr_q.imm};
            M_ADDI:  enc_word = {6'h08, instr_q.rs, instr_q.rt, instr_q.imm};
            M_ADDIU: enc_word = {6'h09, instr_q.rs, instr_q.rt, instr_q.imm};
            M_BEQ:   enc_word = {6'h04, instr_q.rs, instr_q.rt, instr_q.imm};
            M_BNE:   enc_word = {6'h05, instr_q.rs, instr_q.rt, instr_q.imm};
            M_LW:    enc_word = {6'h23, instr_q.rs, instr_q.rt, instr_q.imm};
            M_SW:    enc_word = {6'h2B, instr_q.rs, instr_q.rt, instr_q.imm};
            M_BGTZ:  enc_word = {6'h07, instr_q.rs, 5'd0, instr_q.imm};
            M_BGEZ:  enc_word = {6'h01, instr_q.rs, 5'd1, instr_q.imm};
            M_LUI:   enc_word = {6'h0F, 5'd0, instr_q.rt, instr_q.imm};
            M_J:     enc_word = {6'h02, instr_q.target};
            M_JAL:   enc_word = {6'h03, instr_q.target};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = '{mnem: mnem, rs: rs, rt: rt, rd: rd, shamt: shamt,
                                imm: imm, target: target};
                    state_d = ENC;
                end
            end
            ENC: begin
                if (enc_legal) begin
                    wdata_d = enc_word;
                    state_d = WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                count_d = count_q + (ADDR_WIDTH + 1)'(1);
                if (&ptr_q) begin
                    full_d  = 1'b1;
                    state_d = FULL;
                end else begin
                    state_d = IDLE;
                end
            end
            FULL: state_d = FULL;
            default: state_d = IDLE;
        endcase
        // Rewind wins over accept; a word still in ENC is dropped, a WR strobe already out stands.
        if (restart) begin
            state_d = IDLE;
            instr_d = instr_q;
            wdata_d = wdata_q;
            ptr_d   = '0;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign imem_we    = (state_q == WR);
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed plan cases plus random instruction streams vs. a reference encoder.
module tb_mips_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, restart, in_valid;
    logic          in_ready;
    logic [4:0]    mnem, rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state of the encoder as seen from outside.
    int          m_ptr, m_cnt;
    bit          m_full, m_err;
    logic [31:0] m_wdata;

    mips_instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    // Returns {legal, word} built from the instruction-set field layout.
    function automatic logic [32:0] ref_enc(input int m, input logic [31:0] s, t, d, sh, i, tg);
        logic [31:0] op, w;
        bit ok;
        ok = 1'b1;
        w  = 32'h0;
        op = 32'h0;
        case (m)
            0, 1, 2, 3, 4, 5: w = (s << 21) | (t << 16) | (d << 11) | (32'h20 + 32'(m));
            6:       w = (s << 21) | (t << 16) | (d << 11) | 32'h27;
            10:      w = (s << 21) | (t << 16) | (d << 11) | 32'h2A;
            7:       w = (t << 16) | (d << 11) | (sh << 6);
            8:       w = (t << 16) | (d << 11) | (sh << 6) | 32'h02;
            9:       w = (t << 16) | (d << 11) | (sh << 6) | 32'h03;
            11:      w = (s << 21) | 32'h08;
            12, 13, 14, 15, 16, 17, 18, 21, 22: begin
                case (m)
                    12: op = 32'h0C;  13: op = 32'h0D;  14: op = 32'h0A;
                    15: op = 32'h08;  16: op = 32'h09;  17: op = 32'h04;
                    18: op = 32'h05;  21: op = 32'h23;  default: op = 32'h2B;
                endcase
                w = (op << 26) | (s << 21) | (t << 16) | i;
            end
            19:      w = (32'h07 << 26) | (s << 21) | i;
            20:      w = (32'h01 << 26) | (s << 21) | (32'h1 << 16) | i;
            23:      w = (32'h0F << 26) | (t << 16) | i;
            24:      w = (32'h02 << 26) | tg;
            25:      w = (32'h03 << 26) | tg;
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    task automatic model_rewind();
        m_ptr  = 0;
        m_cnt  = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic scramble_fields();
        mnem   = 5'($urandom);
        rs     = 5'($urandom);
        rt     = 5'($urandom);
        rd     = 5'($urandom);
        shamt  = 5'($urandom);
        imm    = 16'($urandom);
        target = 26'($urandom);
    endtask

    // Starts and ends on a falling edge with the DUT idle (or full).
    task automatic do_instr(input int m, input logic [4:0] a, b, c, sh,
                            input logic [15:0] i, input logic [25:0] tg);
        logic [32:0] r;
        r = ref_enc(m, 32'(a), 32'(b), 32'(c), 32'(sh), 32'(i), 32'(tg));
        mnem = 5'(m); rs = a; rt = b; rd = c; shamt = sh; imm = i; target = tg;
        in_valid = 1'b1;
        if (m_full) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                n_cmp++;
                if (in_ready !== 1'b0 || imem_we !== 1'b0 || count !== m_cnt[AW:0] || full !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_hold: in_ready=%b we=%b count=%0d full=%b, want 0 0 %0d 1",
                             in_ready, imem_we, count, full, m_cnt);
                end
            end
            in_valid = 1'b0;
            return;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_ready: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_fields();
        @(negedge clk);
        n_cmp++;
        if (imem_we !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL enc_cycle: we=%b in_ready=%b, want 0 0", imem_we, in_ready);
        end
        @(negedge clk);
        if (r[32]) begin
            n_cmp++;
            if (imem_we !== 1'b1 || imem_addr !== m_ptr[AW-1:0] || imem_wdata !== r[31:0]) begin
                n_bad++;
                $display("FAIL write m=%0d: we=%b addr=%0d data=%h, want 1 %0d %h",
                         m, imem_we, imem_addr, imem_wdata, m_ptr, r[31:0]);
            end
            m_wdata = r[31:0];
            m_cnt++;
            if (m_ptr == DEPTH - 1) m_full = 1'b1;
            m_ptr = (m_ptr + 1) % DEPTH;
            @(negedge clk);
            n_cmp++;
            if (in_ready !== !m_full || imem_we !== 1'b0 || imem_addr !== m_ptr[AW-1:0] ||
                imem_wdata !== m_wdata || count !== m_cnt[AW:0] || full !== m_full || err !== m_err) begin
                n_bad++;
                $display("FAIL post_write: rdy=%b we=%b addr=%0d data=%h cnt=%0d full=%b err=%b, want %b 0 %0d %h %0d %b %b",
                         in_ready, imem_we, imem_addr, imem_wdata, count, full, err,
                         !m_full, m_ptr, m_wdata, m_cnt, m_full, m_err);
            end
        end else begin
            m_err = 1'b1;
            n_cmp++;
            if (imem_we !== 1'b0 || in_ready !== 1'b1 || err !== 1'b1 ||
                count !== m_cnt[AW:0] || imem_addr !== m_ptr[AW-1:0]) begin
                n_bad++;
                $display("FAIL illegal m=%0d: we=%b rdy=%b err=%b cnt=%0d addr=%0d, want 0 1 1 %0d %0d",
                         m, imem_we, in_ready, err, count, imem_addr, m_cnt, m_ptr);
            end
        end
    endtask

    // Restart with a legal instruction offered in the same cycle: restart must win.
    task automatic do_restart();
        mnem = 5'd0;
        in_valid = 1'b1;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        model_rewind();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || count !== '0 ||
            full !== 1'b0 || err !== 1'b0 || imem_wdata !== m_wdata) begin
            n_bad++;
            $display("FAIL restart: rdy=%b we=%b addr=%0d cnt=%0d full=%b err=%b data=%h, want 1 0 0 0 0 0 %h",
                     in_ready, imem_we, imem_addr, count, full, err, imem_wdata, m_wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0;
        mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_rewind();
        m_wdata = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 ||
            count !== '0 || full !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b we=%b addr=%0d data=%h cnt=%0d full=%b err=%b, want 1 0 0 0 0 0 0",
                     in_ready, imem_we, imem_addr, imem_wdata, count, full, err);
        end
    endtask

    task automatic test_directed();
        do_instr(0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h1234, 26'h3);
        n_cmp++;
        if (m_wdata !== 32'h00221820) begin
            n_bad++;
            $display("FAIL add_const: model=%h, want 00221820", m_wdata);
        end
        do_instr(21, 5'd29, 5'd8, 5'd17, 5'd3, 16'h0004, 26'h5);
        do_instr(7, 5'd7, 5'd5, 5'd2, 5'd4, 16'hBEEF, 26'h1);
        n_cmp++;
        if (imem_wdata !== 32'h00051100) begin
            n_bad++;
            $display("FAIL sll_const: data=%h, want 00051100", imem_wdata);
        end
        do_restart();
        do_instr(20, 5'd4, 5'd19, 5'd6, 5'd1, 16'hFFFE, 26'h7);
        do_instr(25, 5'd3, 5'd3, 5'd3, 5'd3, 16'h3, 26'h0100040);
        n_cmp++;
        if (imem_wdata !== 32'h0C100040) begin
            n_bad++;
            $display("FAIL jal_const: data=%h, want 0C100040", imem_wdata);
        end
        do_instr(24, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h0);
        do_restart();
    endtask

    task automatic test_illegal();
        do_instr(31, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h6);
        do_instr(15, 5'd0, 5'd1, 5'd9, 5'd9, 16'h0005, 26'h9);
        n_cmp++;
        if (imem_wdata !== 32'h20010005 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL addi_after_illegal: data=%h err=%b, want 20010005 1", imem_wdata, err);
        end
        do_restart();
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++)
            do_instr($urandom_range(0, 25), 5'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 16'($urandom), 26'($urandom));
        do_instr(1, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        do_restart();
    endtask

    // Accept a word, then hit it with restart in ENC or with restart/reset in WR.
    task automatic test_abort(input int where_cycle, input bit use_reset);
        logic [32:0] r;
        r = ref_enc(12, 32'd6, 32'd7, 32'd0, 32'd0, 32'hA5A5, 32'd0);
        do_instr(4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        mnem = 5'd12; rs = 5'd6; rt = 5'd7; imm = 16'hA5A5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_fields();
        @(negedge clk);
        if (where_cycle == 2) begin
            @(negedge clk);
            n_cmp++;
            if (imem_we !== 1'b1 || imem_wdata !== r[31:0]) begin
                n_bad++;
                $display("FAIL abort_wr_strobe: we=%b data=%h, want 1 %h", imem_we, imem_wdata, r[31:0]);
            end
            m_wdata = r[31:0];
        end
        if (use_reset) reset = 1'b1; else restart = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        restart = 1'b0;
        model_rewind();
        if (use_reset) m_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || count !== '0 ||
                full !== 1'b0 || err !== 1'b0 || imem_wdata !== m_wdata) begin
                n_bad++;
                $display("FAIL abort c%0d r%0d: rdy=%b we=%b addr=%0d cnt=%0d full=%b err=%b data=%h, want 1 0 0 0 0 0 %h",
                         where_cycle, use_reset, in_ready, imem_we, imem_addr, count, full, err,
                         imem_wdata, m_wdata);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            do_instr($urandom_range(0, 31), 5'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 16'($urandom), 26'($urandom));
            if (m_full && ($urandom_range(0, 1) == 1)) do_restart();
        end
        if (m_full) do_instr(0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_full();
        test_abort(1, 1'b0);
        test_abort(2, 1'b1);
        test_abort(2, 1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time budget");
        $fatal(1);
    end

endmodule
